// File: rtl/vga_pixel_gen.sv
// Pixel-colour stage behind the 800x600 sync generator: two-cycle pipeline producing
// 3-2-3 RGB and aligned syncs, with four test patterns switched only at frame start.
module vga_pixel_gen #(
  parameter int H_VISIBLE = 800,
  parameter int V_VISIBLE = 600,
  parameter int BOX_SIZE  = 32,
  parameter int BOX_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        display_en_in,
  input  logic [10:0] x_pos,
  input  logic [10:0] y_pos,
  input  logic [1:0]  pattern_sel,
  output logic [2:0]  red,
  output logic [1:0]  green,
  output logic [2:0]  blue,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [7:0]  frame_cnt
);

  localparam logic [11:0] STEP  = 12'(BOX_STEP);
  localparam logic [11:0] SIZE  = 12'(BOX_SIZE);
  localparam logic [10:0] X_LIM = 11'(H_VISIBLE - BOX_SIZE);
  localparam logic [10:0] Y_LIM = 11'(V_VISIBLE - BOX_SIZE);
  localparam logic [10:0] X_MID = 11'(H_VISIBLE / 2);
  localparam logic [10:0] Y_MID = 11'(V_VISIBLE / 2);
  localparam int          BW    = H_VISIBLE / 8;

  localparam logic [7:0] C_WHITE   = 8'b111_11_111;
  localparam logic [7:0] C_YELLOW  = 8'b111_11_000;
  localparam logic [7:0] C_CYAN    = 8'b000_11_111;
  localparam logic [7:0] C_GREEN   = 8'b000_11_000;
  localparam logic [7:0] C_MAGENTA = 8'b111_00_111;
  localparam logic [7:0] C_RED     = 8'b111_00_000;
  localparam logic [7:0] C_BLUE    = 8'b000_00_111;
  localparam logic [7:0] C_BLACK   = 8'b000_00_000;
  localparam logic [7:0] C_DKBLUE  = 8'b000_00_010;

  logic [10:0] x1, y1;
  logic        de1, hs1, vs1;
  logic [1:0]  pattern;
  logic [10:0] box_x, box_y;
  logic        dir_x, dir_y;     // 0 = right / down
  logic        frame_tick;
  logic [11:0] x_next, y_next;
  logic [2:0]  bar;
  logic        in_box;
  logic [7:0]  colour;

  // Returns {next_dir, next_pos}; sums are 12 bits wide so the edge test cannot wrap.
  function automatic logic [11:0] bounce(input logic [10:0] pos, input logic dir,
                                         input logic [10:0] lim);
    logic [11:0] sum;
    sum = {1'b0, pos} + STEP;
    if (!dir) begin
      if (sum >= {1'b0, lim}) bounce = {1'b1, lim};
      else                    bounce = {1'b0, sum[10:0]};
    end else begin
      if ({1'b0, pos} <= STEP) bounce = 12'd0;
      else                     bounce = {1'b1, pos - STEP[10:0]};
    end
  endfunction

  assign frame_tick = v_sync_in & ~vs1;
  assign x_next     = bounce(box_x, dir_x, X_LIM);
  assign y_next     = bounce(box_y, dir_y, Y_LIM);

  always_comb begin
    bar = 3'd7;
    if      (x1 < 11'(BW))     bar = 3'd0;
    else if (x1 < 11'(2 * BW)) bar = 3'd1;
    else if (x1 < 11'(3 * BW)) bar = 3'd2;
    else if (x1 < 11'(4 * BW)) bar = 3'd3;
    else if (x1 < 11'(5 * BW)) bar = 3'd4;
    else if (x1 < 11'(6 * BW)) bar = 3'd5;
    else if (x1 < 11'(7 * BW)) bar = 3'd6;

    in_box = ({1'b0, x1} >= {1'b0, box_x}) && ({1'b0, x1} < {1'b0, box_x} + SIZE) &&
             ({1'b0, y1} >= {1'b0, box_y}) && ({1'b0, y1} < {1'b0, box_y} + SIZE);

    colour = C_BLACK;
    case (pattern)
      2'd0: begin
        if (x1 < X_MID) colour = (y1 < Y_MID) ? C_RED  : C_GREEN;
        else            colour = (y1 < Y_MID) ? C_BLUE : C_WHITE;
      end
      2'd1: begin
        case (bar)
          3'd0:    colour = C_WHITE;
          3'd1:    colour = C_YELLOW;
          3'd2:    colour = C_CYAN;
          3'd3:    colour = C_GREEN;
          3'd4:    colour = C_MAGENTA;
          3'd5:    colour = C_RED;
          3'd6:    colour = C_BLUE;
          default: colour = C_BLACK;
        endcase
      end
      2'd2:    colour = in_box ? C_WHITE : C_DKBLUE;
      default: colour = (x1[5] ^ y1[5] ^ frame_cnt[6]) ? C_WHITE : C_BLACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x1 <= '0; y1 <= '0; de1 <= 1'b0; hs1 <= 1'b0; vs1 <= 1'b0;
      pattern <= 2'd0; frame_cnt <= 8'd0;
      box_x <= '0; box_y <= '0; dir_x <= 1'b0; dir_y <= 1'b0;
      {red, green, blue} <= 8'd0;
      h_sync_out <= 1'b0; v_sync_out <= 1'b0;
    end else begin
      x1 <= x_pos; y1 <= y_pos; de1 <= display_en_in; hs1 <= h_sync_in; vs1 <= v_sync_in;
      if (frame_tick) begin
        pattern        <= pattern_sel;
        frame_cnt      <= frame_cnt + 8'd1;
        {dir_x, box_x} <= x_next;
        {dir_y, box_y} <= y_next;
      end
      {red, green, blue} <= de1 ? colour : C_BLACK;
      h_sync_out <= hs1;
      v_sync_out <= vs1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen: a frame-level model predicts every output each cycle,
// and hand-computed literal colours pin the model at the interesting pixels.
module tb_vga_pixel_gen;

  localparam logic [7:0] C_WHITE   = 8'b111_11_111;
  localparam logic [7:0] C_YELLOW  = 8'b111_11_000;
  localparam logic [7:0] C_CYAN    = 8'b000_11_111;
  localparam logic [7:0] C_GREEN   = 8'b000_11_000;
  localparam logic [7:0] C_MAGENTA = 8'b111_00_111;
  localparam logic [7:0] C_RED     = 8'b111_00_000;
  localparam logic [7:0] C_BLUE    = 8'b000_00_111;
  localparam logic [7:0] C_BLACK   = 8'b000_00_000;
  localparam logic [7:0] C_DKBLUE  = 8'b000_00_010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h_sync_in = 1'b0, v_sync_in = 1'b0, display_en_in = 1'b0;
  logic [10:0] x_pos = '0, y_pos = '0;
  logic [1:0]  pattern_sel = '0;
  logic [2:0]  red, blue;
  logic [1:0]  green;
  logic        h_sync_out, v_sync_out;
  logic [7:0]  frame_cnt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  vga_pixel_gen dut (
    .clk(clk), .rst(rst), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .display_en_in(display_en_in), .x_pos(x_pos), .y_pos(y_pos),
    .pattern_sel(pattern_sel), .red(red), .green(green), .blue(blue),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .frame_cnt(frame_cnt)
  );

  // ---------------- model ----------------
  typedef struct packed {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       lit_v;
    logic [7:0] lit;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       exp_cur = '0;
  logic [7:0] exp_fc  = '0;
  logic [7:0] fc_pend = '0;
  logic       chk_en  = 1'b0;
  int         n_cmp = 0, n_bad = 0;
  int         ticks = 0, m_pat = 0;
  logic       prev_vs = 1'b0;

  // Box position after n frames: triangle wave between 0 and lim in steps of 4.
  function automatic int tri_pos(input int n, input int lim);
    int steps, p;
    steps = lim / 4;
    p = n % (2 * steps);
    return (p <= steps) ? 4 * p : 4 * (2 * steps - p);
  endfunction

  function automatic logic [7:0] model_rgb(input int x, input int y, input int pat, input int n);
    int bx, by, fc;
    bx = tri_pos(n, 768);
    by = tri_pos(n, 568);
    fc = n % 256;
    case (pat)
      0: begin
        if (x < 400) return (y < 300) ? C_RED : C_GREEN;
        else         return (y < 300) ? C_BLUE : C_WHITE;
      end
      1: begin
        case ((x / 100 > 7) ? 7 : x / 100)
          0: return C_WHITE;
          1: return C_YELLOW;
          2: return C_CYAN;
          3: return C_GREEN;
          4: return C_MAGENTA;
          5: return C_RED;
          6: return C_BLUE;
          default: return C_BLACK;
        endcase
      end
      2: return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? C_WHITE : C_DKBLUE;
      default: return (((x / 32) + (y / 32) + (fc / 64)) % 2 == 1) ? C_WHITE : C_BLACK;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input int x, input int y, input logic de,
                      input logic hs, input logic vs, input logic [1:0] sel,
                      input logic lv, input logic [7:0] lit);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; x_pos = 11'(x); y_pos = 11'(y); display_en_in = de;
    h_sync_in = hs; v_sync_in = vs; pattern_sel = sel;
    exp_fc = fc_pend;
    e = '0;
    e.lit_v = lv;
    e.lit   = lit;
    if (r) begin
      ticks = 0; m_pat = 0; prev_vs = 1'b0;
      exp_q[$] = '{rgb: 8'd0, hs: 1'b0, vs: 1'b0, lit_v: 1'b1, lit: 8'd0};
    end else begin
      if (vs && !prev_vs) begin
        ticks++;
        m_pat = int'(sel);
      end
      prev_vs = vs;
      e.rgb = de ? model_rgb(x, y, m_pat, ticks) : 8'd0;
      e.hs  = hs;
      e.vs  = vs;
    end
    fc_pend = 8'(ticks % 256);
    exp_q.push_back(e);
    exp_cur = exp_q.pop_front();
  endtask

  task automatic pix(input int x, input int y, input logic [1:0] sel);
    step(1'b0, x, y, 1'b1, 1'b0, 1'b0, sel, 1'b0, 8'd0);
  endtask

  task automatic pixl(input int x, input int y, input logic [1:0] sel, input logic [7:0] lit);
    step(1'b0, x, y, 1'b1, 1'b0, 1'b0, sel, 1'b1, lit);
  endtask

  task automatic frame(input logic [1:0] sel);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, sel, 1'b0, 8'd0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, sel, 1'b0, 8'd0);
  endtask

  task automatic reset_cycles(input int n, input logic [1:0] sel);
    for (int i = 0; i < n; i++) step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, sel, 1'b0, 8'd0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("rgb", {red, green, blue}, exp_cur.rgb);
      cmp("h_sync_out", {7'd0, h_sync_out}, {7'd0, exp_cur.hs});
      cmp("v_sync_out", {7'd0, v_sync_out}, {7'd0, exp_cur.vs});
      cmp("frame_cnt", frame_cnt, exp_fc);
      if (exp_cur.lit_v) cmp("literal_rgb", {red, green, blue}, exp_cur.lit);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int bx, by;
    exp_q.push_back('0);
    exp_q.push_back('0);

    // Reset, then pattern 1 requested: shown only after the first v_sync rise.
    reset_cycles(3, 2'd1);
    chk_en = 1'b1;
    pixl(150, 10, 2'd1, C_RED);
    frame(2'd1);
    @(negedge clk);
    cmp("frame_cnt_first_frame", frame_cnt, 8'd1);
    pixl(150, 10, 2'd1, C_YELLOW);
    pixl(99, 10, 2'd1, C_WHITE);
    pixl(100, 10, 2'd1, C_YELLOW);
    pixl(699, 10, 2'd1, C_BLUE);
    pixl(700, 10, 2'd1, C_BLACK);
    pixl(799, 599, 2'd1, C_BLACK);

    // Quadrant boundaries.
    frame(2'd0);
    pixl(399, 299, 2'd0, C_RED);
    pixl(400, 299, 2'd0, C_BLUE);
    pixl(399, 300, 2'd0, C_GREEN);
    pixl(400, 300, 2'd0, C_WHITE);

    // Blanking with h_sync toggling.
    step(1'b0, 900, 10, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, C_BLACK);
    step(1'b0, 900, 10, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, C_BLACK);
    step(1'b0, 900, 10, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, C_BLACK);
    step(1'b0, 900, 10, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, C_BLACK);
    step(1'b0, 900, 10, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, C_BLACK);

    // Checkerboard, inversion at frame 64, mid-frame pattern_sel ignored.
    reset_cycles(1, 2'd3);
    frame(2'd3);
    pixl(32, 0, 2'd3, C_WHITE);
    pixl(0, 0, 2'd3, C_BLACK);
    for (int i = 0; i < 63; i++) frame(2'd3);
    pixl(32, 0, 2'd3, C_BLACK);
    pixl(0, 0, 2'd3, C_WHITE);
    pixl(32, 0, 2'd0, C_BLACK);
    pixl(32, 32, 2'd1, C_WHITE);
    frame(2'd0);
    pixl(32, 0, 2'd0, C_RED);

    // Reset mid-line with the box at (100,100).
    reset_cycles(1, 2'd2);
    for (int i = 0; i < 25; i++) frame(2'd2);
    pixl(100, 100, 2'd2, C_WHITE);
    pixl(99, 100, 2'd2, C_DKBLUE);
    pixl(131, 131, 2'd2, C_WHITE);
    pixl(132, 100, 2'd2, C_DKBLUE);
    step(1'b1, 120, 100, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, C_BLACK);
    pixl(0, 0, 2'd2, C_RED);
    pixl(450, 350, 2'd2, C_WHITE);
    frame(2'd2);
    pixl(4, 4, 2'd2, C_WHITE);
    pixl(3, 4, 2'd2, C_DKBLUE);
    pixl(36, 4, 2'd2, C_DKBLUE);
    pixl(35, 35, 2'd2, C_WHITE);

    // Bouncing box over 200 frames.
    reset_cycles(1, 2'd2);
    for (int k = 1; k <= 200; k++) begin
      frame(2'd2);
      bx = tri_pos(k, 768);
      by = tri_pos(k, 568);
      pixl(bx, by, 2'd2, C_WHITE);
      pix(bx + 31, by + 31, 2'd2);
      pix((bx < 768) ? bx + 32 : bx - 1, by, 2'd2);
      if (k == 142) begin
        pixl(568, 568, 2'd2, C_WHITE);
        pixl(599, 599, 2'd2, C_WHITE);
        pixl(600, 568, 2'd2, C_DKBLUE);
      end
      if (k == 143) begin
        pixl(572, 564, 2'd2, C_WHITE);
        pixl(571, 564, 2'd2, C_DKBLUE);
      end
      if (k == 192) begin
        pixl(768, 368, 2'd2, C_WHITE);
        pixl(767, 368, 2'd2, C_DKBLUE);
      end
      if (k == 193) begin
        pixl(764, 364, 2'd2, C_WHITE);
        pixl(796, 364, 2'd2, C_DKBLUE);
      end
    end

    // Drain the pipeline so the last inputs are compared.
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 8'd0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 8'd0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 8'd0);
    @(negedge clk);
    @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_gen.md
Name: vga_pixel_gen

Overview:
- Pixel-colour stage directly downstream of the 800x600 VGA sync/timing generator.
- Consumes the generator's h_sync, v_sync, display_en and the current pixel coordinates.
- Produces registered 8-bit RGB (3-2-3) plus matching delayed syncs for the board pins.
- Provides four selectable test patterns, including a per-frame animated bouncing box; pattern changes take effect only at frame boundaries.

Parameters:
- H_VISIBLE, 800, active pixels per line
- V_VISIBLE, 600, active lines per frame
- BOX_SIZE, 32, bouncing-box edge length in pixels
- BOX_STEP, 4, box displacement per frame on each axis (must be < BOX_SIZE)

Ports:
- clk  in  1  pixel clock (same clock as the sync generator)
- rst  in  1  synchronous reset, active-high
- h_sync_in  in  1  horizontal sync from the timing generator (high during pulse)
- v_sync_in  in  1  vertical sync from the timing generator (high during pulse)
- display_en_in  in  1  high while (x_pos, y_pos) is inside the visible area
- x_pos  in  11  current column, 0..1039
- y_pos  in  11  current line, 0..665
- pattern_sel  in  2  requested pattern: 0 quadrants, 1 colour bars, 2 bouncing box, 3 checkerboard
- red  out  3  red component
- green  out  2  green component
- blue  out  3  blue component
- h_sync_out  out  1  h_sync_in delayed to align with RGB
- v_sync_out  out  1  v_sync_in delayed to align with RGB
- frame_cnt  out  8  frames completed since reset, wraps 255->0

Behaviour:
- Everything is clocked on the rising edge of clk; rst is sampled only on clk edges.
- Reset: red/green/blue=0, h_sync_out=0, v_sync_out=0, frame_cnt=0, active pattern=0, box_x=0, box_y=0, box direction right+down, all pipeline registers 0.
- Pipeline, 2 cycles:
  - Stage 1 registers x_pos, y_pos, display_en_in, h_sync_in, v_sync_in.
  - Stage 2 computes the colour from the stage-1 values and registers RGB plus both syncs.
  - An input at cycle N appears on the outputs at cycle N+2, for every input including syncs.
- Blanking: if stage-1 display_en is 0, the registered RGB is 0 (black). Never drive X or Z.
- Frame start: a rising edge of v_sync_in (previous sample 0, current sample 1) produces a one-cycle frame_tick.
- On frame_tick:
  - active pattern <= pattern_sel;
  - frame_cnt <= frame_cnt + 1 (modulo 256);
  - box position updates as described below.
- pattern_sel changes at any other time are ignored until the next frame_tick.
- Pattern 0, quadrants. Boundaries use x<400 and y<300; x=400 belongs to the right half, y=300 to the bottom half.
  - Top-left: red=7, green=0, blue=0.
  - Top-right: 0/0/7.
  - Bottom-left: 0/3/0.
  - Bottom-right: 7/3/7.
- Pattern 1, colour bars: bar index = x/100, computed with a comparison chain (no divider), giving 0..7. Colours in R/G/B:
  - 0 white 7/3/7
  - 1 yellow 7/3/0
  - 2 cyan 0/3/7
  - 3 green 0/3/0
  - 4 magenta 7/0/7
  - 5 red 7/0/0
  - 6 blue 0/0/7
  - 7 black 0/0/0
- Pattern 2, bouncing box:
  - Pixel colour is white 7/3/7 when box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE; otherwise dark blue 0/0/2.
  - Box state (box_x, box_y: 11 bits; dir_x, dir_y: 1 bit each) updates only on frame_tick, regardless of the active pattern.
  - Moving right: if box_x + BOX_STEP >= H_VISIBLE-BOX_SIZE, then box_x <= H_VISIBLE-BOX_SIZE and dir_x <= left; else box_x <= box_x + BOX_STEP.
  - Moving left: if box_x <= BOX_STEP, then box_x <= 0 and dir_x <= right; else box_x <= box_x - BOX_STEP.
  - Y axis follows the same rules with V_VISIBLE.
  - Box is never outside the visible area.
- Pattern 3, checkerboard: white when (x[5] ^ y[5] ^ frame_cnt[6]) = 1, else black. The 32-px squares invert every 64 frames.
- Arithmetic: all compares are unsigned at 11 bits; the sums box_x+BOX_SIZE and box_x+BOX_STEP are evaluated at 12 bits so no overflow occurs.
- Reset mid-frame: outputs go to their reset values on the next edge. Animation restarts at (0,0) and the pattern reverts to 0 until the next frame_tick.
- Simultaneous rst and frame_tick: rst wins.

Test Plan:
- Reset held 3 cycles, then pattern_sel=1 from the first frame. The first full frame shows pattern 0 and the second shows pattern 1; frame_cnt=1 after the first v_sync rise, and (x=150,y=10) outputs 7/3/0.
- Pattern 0, sample pixels (399,299), (400,299), (399,300), (400,300). Required outputs are 7/0/0, 0/0/7, 0/3/0 and 7/3/7, each appearing exactly 2 cycles after its input.
- Any pattern, display_en_in=0 with x=900 (blanking). RGB=0, and h_sync_out reproduces h_sync_in delayed by exactly 2 cycles.
- Pattern 2 over 200 frames with defaults:
  - box_x sequence 0, 4, 8 ... 764, 768, then 764;
  - box_y reaches 568 at frame 142, then decreases;
  - pixel (box_x, box_y) is white and (box_x+32, box_y) is 0/0/2.
- Pattern 3: pixel (32,0) is white at frame_cnt=0 and black at frame_cnt=64. pattern_sel toggled mid-frame does not change the output before the next v_sync rise.
- Assert rst mid-line during pattern 2 at box_x=100. Outputs are 0 on the next edge, and after release box_x=0 and the active pattern is 0.
